// File: rtl/nrzi_decoder_if.sv
// Serial-line receive bus between the receiver control (master) and nrzi_decoder (slave).
// stuff_err exists only when NRZI_DECODER_UNSTUFF_EN is defined.
interface nrzi_decoder_if;
    logic enable;
    logic d_line;
    logic d_orig;
    logic bit_valid;
`ifdef NRZI_DECODER_UNSTUFF_EN
    logic stuff_err;

    modport master (
        output enable,
        output d_line,
        input  d_orig,
        input  bit_valid,
        input  stuff_err
    );

    modport slave (
        input  enable,
        input  d_line,
        output d_orig,
        output bit_valid,
        output stuff_err
    );
`else
    modport master (
        output enable,
        output d_line,
        input  d_orig,
        input  bit_valid
    );

    modport slave (
        input  enable,
        input  d_line,
        output d_orig,
        output bit_valid
    );
`endif
endinterface

// File: rtl/nrzi_decoder.sv
// NRZI receive decoder: line synchronizer, edge-resynced bit timing, centre sampling, NRZI reversal.
// Define NRZI_DECODER_UNSTUFF_EN to drop the bit following six 1s and flag stuffing errors.
module nrzi_decoder #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT = 3
) (
    input  logic           clk,
    input  logic           rst,
    nrzi_decoder_if.slave  bus
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t CNT_LAST   = cnt_t'(CLKS_PER_BIT - 1);
    localparam cnt_t CNT_SAMPLE = cnt_t'(SAMPLE_POINT);

    if (CLKS_PER_BIT < 4) begin : g_bad_cpb
        $error("nrzi_decoder: CLKS_PER_BIT must be at least 4");
    end
    if (SAMPLE_POINT < 1 || SAMPLE_POINT > CLKS_PER_BIT - 2) begin : g_bad_sp
        $error("nrzi_decoder: SAMPLE_POINT must be in 1..CLKS_PER_BIT-2");
    end

    logic sync1;
    logic d_sync;
    logic d_last;
    cnt_t cnt;
    cnt_t cnt_next;
    logic prev_level;
    logic prev_level_next;
    logic d_orig_q;
    logic d_orig_next;
    logic bit_valid_q;
    logic bit_valid_next;

    logic line_edge;
    logic sample;
    logic decoded;

`ifdef NRZI_DECODER_UNSTUFF_EN
    logic [2:0] ones_cnt;
    logic [2:0] ones_cnt_next;
    logic       stuff_err_q;
    logic       stuff_err_next;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1       <= 1'b1;
            d_sync      <= 1'b1;
            d_last      <= 1'b1;
            cnt         <= '0;
            prev_level  <= 1'b1;
            d_orig_q    <= 1'b1;
            bit_valid_q <= 1'b0;
        end else begin
            sync1       <= bus.d_line;
            d_sync      <= sync1;
            d_last      <= d_sync;
            cnt         <= cnt_next;
            prev_level  <= prev_level_next;
            d_orig_q    <= d_orig_next;
            bit_valid_q <= bit_valid_next;
        end
    end

`ifdef NRZI_DECODER_UNSTUFF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_cnt    <= '0;
            stuff_err_q <= 1'b0;
        end else begin
            ones_cnt    <= ones_cnt_next;
            stuff_err_q <= stuff_err_next;
        end
    end
`endif

    // An edge in the sample cycle wins: the counter resyncs and that sample is skipped.
    always_comb begin
        line_edge = d_sync ^ d_last;
        sample    = bus.enable && (cnt == CNT_SAMPLE) && !line_edge;
        decoded   = (d_sync == prev_level);
    end

    always_comb begin
        cnt_next = '0;
        if (bus.enable) begin
            if (line_edge) begin
                cnt_next = cnt_t'(1);
            end else if (cnt == CNT_LAST) begin
                cnt_next = '0;
            end else begin
                cnt_next = cnt + cnt_t'(1);
            end
        end
    end

    // While idle, prev_level follows the line so the first bit decodes against the idle level.
    always_comb begin
        prev_level_next = prev_level;
        if (!bus.enable || sample) begin
            prev_level_next = d_sync;
        end
    end

`ifdef NRZI_DECODER_UNSTUFF_EN
    always_comb begin
        d_orig_next    = d_orig_q;
        bit_valid_next = 1'b0;
        ones_cnt_next  = ones_cnt;
        stuff_err_next = stuff_err_q;
        if (!bus.enable) begin
            ones_cnt_next  = '0;
            stuff_err_next = 1'b0;
        end else if (sample) begin
            if (ones_cnt == 3'd6) begin
                // Stuffed bit: swallowed silently, a 1 here means the sender broke the rule.
                ones_cnt_next = '0;
                if (decoded) begin
                    stuff_err_next = 1'b1;
                end
            end else begin
                bit_valid_next = 1'b1;
                d_orig_next    = decoded;
                ones_cnt_next  = decoded ? ones_cnt + 3'd1 : '0;
            end
        end
    end

    assign bus.stuff_err = stuff_err_q;
`else
    always_comb begin
        d_orig_next    = d_orig_q;
        bit_valid_next = 1'b0;
        if (sample) begin
            bit_valid_next = 1'b1;
            d_orig_next    = decoded;
        end
    end
`endif

    assign bus.d_orig    = d_orig_q;
    assign bus.bit_valid = bit_valid_q;

endmodule

// File: tb/tb_nrzi_decoder.sv
// Directed bench for nrzi_decoder with default parameters (8 clocks/bit, sample at 3).
// Unstuffing steps run only when NRZI_DECODER_UNSTUFF_EN is defined.
module tb_nrzi_decoder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    nrzi_decoder_if bus ();

    nrzi_decoder #(
        .CLKS_PER_BIT (8),
        .SAMPLE_POINT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0;
    int   n_bad = 0;
    logic exp_orig;
    logic exp_stuff;
    bit   hold_chk;
    logic [7:0] tx_byte;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic want);
        n_vec++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    task automatic chk_out(input string tag, input logic want_valid, input logic want_orig);
        chk({tag, "/valid"}, bus.bit_valid, want_valid);
        if (want_valid || hold_chk) chk({tag, "/orig"}, bus.d_orig, want_orig);
`ifdef NRZI_DECODER_UNSTUFF_EN
        chk({tag, "/stuff"}, bus.stuff_err, exp_stuff);
`endif
    endtask

    // One clock, then check the registered outputs 1 time unit after the edge.
    task automatic cyc(input string tag, input logic want_valid, input logic want_orig);
        tick;
        chk_out(tag, want_valid, want_orig);
    endtask

    initial begin
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.d_line  = 1'b1;
        exp_orig    = 1'b1;
        exp_stuff   = 1'b0;
        hold_chk    = 1'b1;
        tx_byte     = 8'h80;

        repeat (3) tick;
        chk_out("por", 1'b0, 1'b1);

        // Get a strobe carrying 0, then hit reset asynchronously inside that strobe cycle.
        rst        = 1'b0;
        bus.enable = 1'b1;
        bus.d_line = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            if (i == 6) exp_orig = 1'b0;
            cyc("pre", i == 6, exp_orig);
        end
        #3;
        rst = 1'b1;
        #1;
        exp_orig = 1'b1;
        chk_out("async_rst", 1'b0, 1'b1);
        bus.d_line = 1'b1;
        repeat (2) cyc("in_rst", 1'b0, 1'b1);
        rst = 1'b0;

        // Idle line: free-running strobes of 1 every 8 clocks.
        for (int i = 1; i <= 40; i++) cyc("idle", (i % 8) == 4, 1'b1);

        // Single toggle: strobe 6 clocks later with 0, then 8 more with 1.
        bus.d_line = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 6)  exp_orig = 1'b0;
            if (i == 14) exp_orig = 1'b1;
            cyc("resync", i == 6 || i == 14, exp_orig);
        end

        // Park on an idle-high line, then send 0x80 LSB first through an NRZI encoder model.
        bus.enable = 1'b0;
        bus.d_line = 1'b1;
        repeat (4) cyc("park", 1'b0, exp_orig);
        bus.enable = 1'b1;
        if (!tx_byte[0]) bus.d_line = ~bus.d_line;
        for (int i = 1; i <= 63; i++) begin
            logic strobe;
            strobe = (i >= 6) && (((i - 6) % 8) == 0);
            if (strobe) exp_orig = tx_byte[(i - 6) / 8];
            cyc("byte", strobe, exp_orig);
            if ((i % 8) == 0 && (i / 8) < 8) begin
                if (!tx_byte[i / 8]) bus.d_line = ~bus.d_line;
            end
        end

        // Edge landing exactly on the sample count: no strobe there, one 3 clocks after it + 1.
        for (int i = 64; i <= 67; i++) cyc("pre_collide", 1'b0, exp_orig);
        bus.d_line = ~bus.d_line;
        for (int i = 68; i <= 75; i++) begin
            if (i == 73) exp_orig = 1'b0;
            cyc("collide", i == 73, exp_orig);
        end

        // Partial bit abandoned by enable falling at cnt=2; next decode uses the current level.
        bus.d_line = ~bus.d_line;
        for (int i = 76; i <= 79; i++) cyc("pre_drop", 1'b0, exp_orig);
        bus.enable = 1'b0;
        for (int i = 80; i <= 85; i++) cyc("dropped", 1'b0, exp_orig);
        bus.enable = 1'b1;
        for (int i = 86; i <= 90; i++) begin
            if (i == 89) exp_orig = 1'b1;
            cyc("reenable", i == 89, exp_orig);
        end

`ifdef NRZI_DECODER_UNSTUFF_EN
        hold_chk = 1'b0;

        // Six 1s then a toggled (0) stuffed bit: swallowed, no error.
        bus.enable = 1'b0;
        bus.d_line = 1'b1;
        repeat (4) cyc("stuff_park", 1'b0, 1'b1);
        bus.enable = 1'b1;
        for (int i = 1; i <= 56; i++) begin
            cyc("stuff_ok", (i % 8) == 4 && i <= 44, 1'b1);
            if (i == 46) bus.d_line = 1'b0;
        end

        // Seven 1s: the stuffed slot decodes to 1 and raises a sticky error.
        bus.enable = 1'b0;
        repeat (4) cyc("stuff_park2", 1'b0, 1'b1);
        bus.enable = 1'b1;
        for (int i = 1; i <= 62; i++) begin
            if (i == 52) exp_stuff = 1'b1;
            cyc("stuff_bad", (i % 8) == 4 && i != 52, 1'b1);
        end
        bus.enable = 1'b0;
        exp_stuff  = 1'b0;
        cyc("stuff_clr", 1'b0, 1'b1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
